pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
//  Parametrised central hazard/stall controller for the in-order pipeline; replaces the fixed 5-stage controller.
//  Resolves source operands through an N-deep bypass network, detects load-use/data hazards, tracks in-flight
//  branches in a shadow shift register, and issues per-stage STALL/FLUSH controls plus PC redirect on mispredict.
//  Sits beside the stage registers; drives every pipeline-register control and the fetch redirect.
// PARAMETERS
//  NUM_STAGES      5   pipeline registers controlled (index 0 = fetch->decode register)
//  BYPASS_DEPTH    2   forwarding sources, index 0 = youngest (nearest) producer
//  RESOLVE_STAGE   2   stage index where branches resolve; 1 <= RESOLVE_STAGE < NUM_STAGES
//  STALL_ON_BRANCH 1   1: bubble fetch while a predicted-not-taken branch is unresolved; 0: speculate
//  REG_ADDR_W      5   register address width
//  DATA_W          32  data / PC width
// PORTS
//  clk             in   1                      clock
//  rst             in   1                      synchronous reset, active-high
//  src1Addr/src2Addr in REG_ADDR_W             decode-stage source register addresses
//  src1Used/src2Used in 1                      source actually read (op type / store)
//  rfSrc1Data/rfSrc2Data in DATA_W             register-file read data
//  fwdValid        in   BYPASS_DEPTH           producer writes a register
//  fwdAddr         in   BYPASS_DEPTH*REG_ADDR_W destination addresses
//  fwdData         in   BYPASS_DEPTH*DATA_W    producer results
//  fwdReady        in   BYPASS_DEPTH           result available this cycle (0 = load in flight)
//  fetchIsBranch   in   1                      fetch holds a branch/jump
//  fetchPredTaken  in   1                      predictor says taken
//  resolveValid    in   1                      branch at RESOLVE_STAGE this cycle
//  resolveTaken/resolvePredTaken in 1          actual / predicted outcome
//  resolveTarget/resolveFallthru in DATA_W     taken target / PC+4
//  stageCtrl       out  2*NUM_STAGES           per register: 00 NORMAL, 01 STALL, 10 FLUSH
//  redirectValid   out  1                      load redirectPc into PC
//  redirectPc      out  DATA_W                 corrected PC
//  bypassedSrc1/bypassedSrc2 out DATA_W        resolved operands
//  dataHazard      out  1                      decode held this cycle
// BEHAVIOUR
//  Bypass (comb): per source, lowest index i with fwdValid[i] && fwdAddr[i]==srcAddr && srcAddr!=0 wins;
//   none -> rf data. Address 0 never forwarded, never hazards.
//  dataHazard = srcUsed && winning match has fwdReady==0 (either source).
//  miss = resolveValid && (resolveTaken != resolvePredTaken); redirectPc = resolveTaken ? target : fallthru.
//  Shadow: register shadow[RESOLVE_STAGE-1:0]; bit0 <= fetchIsBranch && !fetchPredTaken; shifts up each cycle
//   dataHazard==0; holds when dataHazard==1; cleared to 0 on miss (same edge). branchHazard = |shadow && STALL_ON_BRANCH.
//  stageCtrl priority (comb): miss > dataHazard > branchHazard > NORMAL.
//   miss: regs 0..RESOLVE_STAGE-1 FLUSH, rest NORMAL, redirectValid=1.
//   dataHazard: reg0 STALL, reg1 FLUSH (bubble into stage 2), rest NORMAL.
//   branchHazard: reg0 FLUSH, rest NORMAL; fetch PC held by fetch stage.
//  Miss with concurrent dataHazard: miss wins, hazard ignored (stalled instr is flushed).
//  Reset: shadow=0, all counters=0; while rst=1 stageCtrl forced all FLUSH, redirectValid=0; bypass paths live.
//  Reset mid-operation discards shadow state; first post-reset cycle is all NORMAL unless inputs say otherwise.
// CONFIGURATION
//  HAZARD_PERF_EN defined: add outputs perfStallCycles, perfFlushEvents, perfBranchBubbles (32b each, saturating);
//   +1 on each cycle dataHazard / miss / branchHazard respectively; cleared by rst.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 fwd0 & fwd1 both hit src1=x5, ready -> bypassedSrc1=fwdData[0]; src1=x0 hit -> rf data, no hazard.
//  2 fwd0 hits src2=x7, fwdReady[0]=0, src2Used=1 -> dataHazard=1, ctrl reg0=01 reg1=10; src2Used=0 -> NORMAL.
//  3 pred NT branch fetched, RESOLVE_STAGE=2 -> shadow 01,10,00; reg0 FLUSH 2 cycles; STALL_ON_BRANCH=0 -> none.
//  4 resolveValid, taken=1 pred=0, target=0x100 -> redirectValid=1, redirectPc=0x100, regs0,1 FLUSH, shadow=0 next.
//  5 miss and dataHazard same cycle -> miss controls only; rst mid-shadow -> shadow=0, counters 0 (PERF_EN).
//  6 dataHazard during shadow=01 for 3 cycles -> shadow holds 01, then shifts when hazard clears.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Central hazard/stall controller: operand bypass, load-use detection, branch shadow and per-stage control.
// Optional HAZARD_PERF_EN adds saturating stall / flush / branch-bubble performance counters.
module pipeline_hazard_unit #(
    parameter int NUM_STAGES      = 5,
    parameter int BYPASS_DEPTH    = 2,
    parameter int RESOLVE_STAGE   = 2,
    parameter int STALL_ON_BRANCH = 1,
    parameter int REG_ADDR_W      = 5,
    parameter int DATA_W          = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REG_ADDR_W-1:0]          src1Addr,
    input  logic [REG_ADDR_W-1:0]          src2Addr,
    input  logic                           src1Used,
    input  logic                           src2Used,
    input  logic [DATA_W-1:0]              rfSrc1Data,
    input  logic [DATA_W-1:0]              rfSrc2Data,
    input  logic [BYPASS_DEPTH-1:0]        fwdValid,
    input  logic [BYPASS_DEPTH*REG_ADDR_W-1:0] fwdAddr,
    input  logic [BYPASS_DEPTH*DATA_W-1:0] fwdData,
    input  logic [BYPASS_DEPTH-1:0]        fwdReady,
    input  logic                           fetchIsBranch,
    input  logic                           fetchPredTaken,
    input  logic                           resolveValid,
    input  logic                           resolveTaken,
    input  logic                           resolvePredTaken,
    input  logic [DATA_W-1:0]              resolveTarget,
    input  logic [DATA_W-1:0]              resolveFallthru,
    output logic [2*NUM_STAGES-1:0]        stageCtrl,
    output logic                           redirectValid,
    output logic [DATA_W-1:0]              redirectPc,
    output logic [DATA_W-1:0]              bypassedSrc1,
    output logic [DATA_W-1:0]              bypassedSrc2,
    output logic                           dataHazard
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                    perfStallCycles,
    output logic [31:0]                    perfFlushEvents,
    output logic [31:0]                    perfBranchBubbles
`endif
);

    typedef enum logic [1:0] {
        CTRL_NORMAL = 2'b00,
        CTRL_STALL  = 2'b01,
        CTRL_FLUSH  = 2'b10
    } ctrl_e;

    logic                     src1_hit, src1_ready;
    logic                     src2_hit, src2_ready;
    logic                     miss;
    logic                     new_branch;
    logic                     branch_hazard;
    logic [RESOLVE_STAGE-1:0] shadow_q, shadow_d;

    // Scan from the oldest producer down so the youngest matching one is left in place.
    always_comb begin
        src1_hit     = 1'b0;
        src1_ready   = 1'b1;
        bypassedSrc1 = rfSrc1Data;
        src2_hit     = 1'b0;
        src2_ready   = 1'b1;
        bypassedSrc2 = rfSrc2Data;
        for (int i = BYPASS_DEPTH - 1; i >= 0; i--) begin
            if (fwdValid[i] && (fwdAddr[i*REG_ADDR_W +: REG_ADDR_W] == src1Addr) && (src1Addr != '0)) begin
                src1_hit     = 1'b1;
                src1_ready   = fwdReady[i];
                bypassedSrc1 = fwdData[i*DATA_W +: DATA_W];
            end
            if (fwdValid[i] && (fwdAddr[i*REG_ADDR_W +: REG_ADDR_W] == src2Addr) && (src2Addr != '0)) begin
                src2_hit     = 1'b1;
                src2_ready   = fwdReady[i];
                bypassedSrc2 = fwdData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign dataHazard    = (src1Used && src1_hit && !src1_ready) || (src2Used && src2_hit && !src2_ready);
    assign miss          = resolveValid && (resolveTaken != resolvePredTaken);
    assign redirectPc    = resolveTaken ? resolveTarget : resolveFallthru;
    assign new_branch    = fetchIsBranch && !fetchPredTaken;
    assign branch_hazard = (|shadow_q) && (STALL_ON_BRANCH != 0);

    // Shadow bits age toward the resolve stage; a held decode stage freezes their age.
    always_comb begin
        shadow_d = shadow_q;
        if (miss) begin
            shadow_d = '0;
        end else if (!dataHazard) begin
            shadow_d = (shadow_q << 1) | RESOLVE_STAGE'(new_branch);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        stageCtrl     = '0;
        redirectValid = 1'b0;
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stageCtrl[2*i +: 2] = CTRL_FLUSH;
            end
        end else if (miss) begin
            redirectValid = 1'b1;
            for (int i = 0; i < RESOLVE_STAGE; i++) begin
                stageCtrl[2*i +: 2] = CTRL_FLUSH;
            end
        end else if (dataHazard) begin
            stageCtrl[1:0] = CTRL_STALL;
            stageCtrl[3:2] = CTRL_FLUSH;
        end else if (branch_hazard) begin
            stageCtrl[1:0] = CTRL_FLUSH;
        end else begin
            stageCtrl[1:0] = CTRL_NORMAL;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_flush_d  = perf_flush_q;
        perf_bubble_d = perf_bubble_q;
        if (dataHazard && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (miss && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
        if (branch_hazard && (perf_bubble_q != '1)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_flush_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perfStallCycles   = perf_stall_q;
    assign perfFlushEvents   = perf_flush_q;
    assign perfBranchBubbles = perf_bubble_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed scenarios plus randomized cycles against
// a queue-based reference model of in-flight branches.
module tb_pipeline_hazard_unit;

    localparam int NS = 5;
    localparam int RS = 2;

    logic        clk;
    logic        rst;
    logic [4:0]  src1Addr, src2Addr;
    logic        src1Used, src2Used;
    logic [31:0] rfSrc1Data, rfSrc2Data;
    logic [1:0]  fwdValid, fwdReady;
    logic [4:0]  fa [2];
    logic [31:0] fd [2];
    logic [9:0]  fwdAddrBus;
    logic [63:0] fwdDataBus;
    logic        fetchIsBranch, fetchPredTaken;
    logic        resolveValid, resolveTaken, resolvePredTaken;
    logic [31:0] resolveTarget, resolveFallthru;

    logic [9:0]  stageCtrl, stageCtrl2;
    logic        redirectValid, redirectValid2;
    logic [31:0] redirectPc, redirectPc2;
    logic [31:0] bypassedSrc1, bypassedSrc1b, bypassedSrc2, bypassedSrc2b;
    logic        dataHazard, dataHazard2;

    int checks = 0;
    int passes = 0;

    // Reference model: ages of unresolved not-taken branches, 0 = just fetched.
    int ages[$];
    int m_stall = 0, m_flush = 0, m_bubble = 0;

    assign fwdAddrBus = {fa[1], fa[0]};
    assign fwdDataBus = {fd[1], fd[0]};

`ifdef HAZARD_PERF_EN
    logic [31:0] perfStallCycles, perfFlushEvents, perfBranchBubbles;
    logic [31:0] perfStall2, perfFlush2, perfBubble2;
`endif

    pipeline_hazard_unit #(.NUM_STAGES(NS), .BYPASS_DEPTH(2), .RESOLVE_STAGE(RS),
                           .STALL_ON_BRANCH(1), .REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .src1Addr(src1Addr), .src2Addr(src2Addr), .src1Used(src1Used), .src2Used(src2Used),
        .rfSrc1Data(rfSrc1Data), .rfSrc2Data(rfSrc2Data),
        .fwdValid(fwdValid), .fwdAddr(fwdAddrBus), .fwdData(fwdDataBus), .fwdReady(fwdReady),
        .fetchIsBranch(fetchIsBranch), .fetchPredTaken(fetchPredTaken),
        .resolveValid(resolveValid), .resolveTaken(resolveTaken), .resolvePredTaken(resolvePredTaken),
        .resolveTarget(resolveTarget), .resolveFallthru(resolveFallthru),
        .stageCtrl(stageCtrl), .redirectValid(redirectValid), .redirectPc(redirectPc),
        .bypassedSrc1(bypassedSrc1), .bypassedSrc2(bypassedSrc2), .dataHazard(dataHazard)
`ifdef HAZARD_PERF_EN
        , .perfStallCycles(perfStallCycles), .perfFlushEvents(perfFlushEvents),
        .perfBranchBubbles(perfBranchBubbles)
`endif
    );

    pipeline_hazard_unit #(.NUM_STAGES(NS), .BYPASS_DEPTH(2), .RESOLVE_STAGE(RS),
                           .STALL_ON_BRANCH(0), .REG_ADDR_W(5), .DATA_W(32)) dut_spec (
        .clk(clk), .rst(rst),
        .src1Addr(src1Addr), .src2Addr(src2Addr), .src1Used(src1Used), .src2Used(src2Used),
        .rfSrc1Data(rfSrc1Data), .rfSrc2Data(rfSrc2Data),
        .fwdValid(fwdValid), .fwdAddr(fwdAddrBus), .fwdData(fwdDataBus), .fwdReady(fwdReady),
        .fetchIsBranch(fetchIsBranch), .fetchPredTaken(fetchPredTaken),
        .resolveValid(resolveValid), .resolveTaken(resolveTaken), .resolvePredTaken(resolvePredTaken),
        .resolveTarget(resolveTarget), .resolveFallthru(resolveFallthru),
        .stageCtrl(stageCtrl2), .redirectValid(redirectValid2), .redirectPc(redirectPc2),
        .bypassedSrc1(bypassedSrc1b), .bypassedSrc2(bypassedSrc2b), .dataHazard(dataHazard2)
`ifdef HAZARD_PERF_EN
        , .perfStallCycles(perfStall2), .perfFlushEvents(perfFlush2),
        .perfBranchBubbles(perfBubble2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Youngest valid producer with a matching nonzero address supplies the operand.
    function automatic void model_bypass(input logic [4:0] a, input logic [31:0] rf, input logic used,
                                         output logic [31:0] val, output bit stall);
        bit found = 0;
        val   = rf;
        stall = 0;
        if (a != 5'd0) begin
            for (int i = 0; i < 2; i++) begin
                if (!found && fwdValid[i] && fa[i] == a) begin
                    found = 1;
                    val   = fd[i];
                    stall = used && !fwdReady[i];
                end
            end
        end
    endfunction

    function automatic bit model_hazard();
        logic [31:0] v;
        bit s1, s2;
        model_bypass(src1Addr, rfSrc1Data, src1Used, v, s1);
        model_bypass(src2Addr, rfSrc2Data, src2Used, v, s2);
        return s1 || s2;
    endfunction

    function automatic bit model_miss();
        return resolveValid && (resolveTaken != resolvePredTaken);
    endfunction

    function automatic logic [9:0] model_ctrl(input bit stall_on_branch);
        int code [NS];
        logic [9:0] packed_ctrl = '0;
        for (int i = 0; i < NS; i++) code[i] = 0;
        if (rst) begin
            for (int i = 0; i < NS; i++) code[i] = 2;
        end else if (model_miss()) begin
            for (int i = 0; i < RS; i++) code[i] = 2;
        end else if (model_hazard()) begin
            code[0] = 1;
            code[1] = 2;
        end else if (stall_on_branch && ages.size() > 0) begin
            code[0] = 2;
        end
        for (int i = 0; i < NS; i++) packed_ctrl[2*i +: 2] = 2'(code[i]);
        return packed_ctrl;
    endfunction

    // Clock-edge update of the model using the inputs held across the edge.
    function automatic void model_advance();
        int kept[$];
        if (rst) begin
            ages.delete();
            m_stall = 0; m_flush = 0; m_bubble = 0;
        end else begin
            if (model_hazard()) m_stall++;
            if (model_miss()) m_flush++;
            if (ages.size() > 0) m_bubble++;
            if (model_miss()) begin
                ages.delete();
            end else if (!model_hazard()) begin
                foreach (ages[k]) if (ages[k] + 1 < RS) kept.push_back(ages[k] + 1);
                ages = kept;
                if (fetchIsBranch && !fetchPredTaken) ages.push_back(0);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        src1Addr = 0; src2Addr = 0; src1Used = 0; src2Used = 0;
        rfSrc1Data = 32'h1111_0001; rfSrc2Data = 32'h2222_0002;
        fwdValid = 0; fwdReady = 2'b11;
        fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0;
        fetchIsBranch = 0; fetchPredTaken = 0;
        resolveValid = 0; resolveTaken = 0; resolvePredTaken = 0;
        resolveTarget = 32'h0; resolveFallthru = 32'h0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus_random();
        rst = ($urandom_range(0, 39) == 0);
        src1Addr = 5'($urandom_range(0, 3)); src2Addr = 5'($urandom_range(0, 3));
        src1Used = 1'($urandom); src2Used = 1'($urandom);
        rfSrc1Data = $urandom; rfSrc2Data = $urandom;
        fwdValid = 2'($urandom);
        fwdReady = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        for (int i = 0; i < 2; i++) begin
            fa[i] = 5'($urandom_range(0, 3));
            fd[i] = $urandom;
        end
        fetchIsBranch = ($urandom_range(0, 2) == 0); fetchPredTaken = 1'($urandom);
        resolveValid = ($urandom_range(0, 3) == 0);
        resolveTaken = 1'($urandom); resolvePredTaken = 1'($urandom);
        resolveTarget = $urandom; resolveFallthru = $urandom;
    endtask

    task automatic test_reset();
        rst = 1;
        applyStimulus_random();
        rst = 1;
        src1Addr = 5'd3; fa[0] = 5'd3; fwdValid = 2'b01; fd[0] = 32'hCAFE_0003;
        resolveValid = 1; resolveTaken = 1; resolvePredTaken = 0;
        #1;
        checks++; if (stageCtrl !== 10'h2AA) $display("[TB] FAIL reset_ctrl: got %h expected %h", stageCtrl, 10'h2AA); else passes++;
        checks++; if (redirectValid !== 1'b0) $display("[TB] FAIL reset_redirect: got %b expected 0", redirectValid); else passes++;
        checks++; if (bypassedSrc1 !== 32'hCAFE_0003) $display("[TB] FAIL reset_bypass: got %h expected %h", bypassedSrc1, 32'hCAFE_0003); else passes++;
        tick();
        tick();
        rst = 0;
        clear_inputs();
        #1;
        checks++; if (stageCtrl !== 10'h000) $display("[TB] FAIL post_reset_ctrl: got %h expected %h", stageCtrl, 10'h000); else passes++;
        tick();
    endtask

    task automatic test_bypass();
        idle(3);
        src1Addr = 5'd5; src1Used = 1;
        fwdValid = 2'b11; fa[0] = 5'd5; fa[1] = 5'd5; fd[0] = 32'hAAAA_0000; fd[1] = 32'hBBBB_0000;
        #1;
        checks++; if (bypassedSrc1 !== 32'hAAAA_0000) $display("[TB] FAIL bypass_youngest: got %h expected %h", bypassedSrc1, 32'hAAAA_0000); else passes++;
        fa[0] = 5'd6;
        #1;
        checks++; if (bypassedSrc1 !== 32'hBBBB_0000) $display("[TB] FAIL bypass_older: got %h expected %h", bypassedSrc1, 32'hBBBB_0000); else passes++;
        src1Addr = 5'd0; fa[0] = 5'd0; fwdReady = 2'b00; rfSrc1Data = 32'h0000_1234;
        #1;
        checks++; if (bypassedSrc1 !== 32'h0000_1234) $display("[TB] FAIL bypass_x0: got %h expected %h", bypassedSrc1, 32'h0000_1234); else passes++;
        checks++; if (dataHazard !== 1'b0) $display("[TB] FAIL x0_no_hazard: got %b expected 0", dataHazard); else passes++;
        tick();
    endtask

    task automatic test_data_hazard();
        idle(3);
        src2Addr = 5'd7; src2Used = 1; fwdValid = 2'b01; fa[0] = 5'd7; fwdReady = 2'b10;
        #1;
        checks++; if (dataHazard !== 1'b1) $display("[TB] FAIL load_use_hazard: got %b expected 1", dataHazard); else passes++;
        checks++; if (stageCtrl !== 10'h009) $display("[TB] FAIL load_use_ctrl: got %h expected %h", stageCtrl, 10'h009); else passes++;
        src2Used = 0;
        #1;
        checks++; if (stageCtrl !== 10'h000) $display("[TB] FAIL unused_src_ctrl: got %h expected %h", stageCtrl, 10'h000); else passes++;
        tick();
    endtask

    task automatic test_branch_shadow();
        logic [9:0] want [3];
        want[0] = 10'h002; want[1] = 10'h002; want[2] = 10'h000;
        idle(3);
        fetchIsBranch = 1; fetchPredTaken = 0;
        tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (stageCtrl !== want[c]) $display("[TB] FAIL shadow_ctrl_%0d: got %h expected %h", c, stageCtrl, want[c]); else passes++;
            checks++; if (stageCtrl2 !== 10'h000) $display("[TB] FAIL speculate_ctrl_%0d: got %h expected %h", c, stageCtrl2, 10'h000); else passes++;
            tick();
        end
    endtask

    task automatic test_mispredict();
        idle(3);
        fetchIsBranch = 1; fetchPredTaken = 0;
        tick();
        clear_inputs();
        resolveValid = 1; resolveTaken = 1; resolvePredTaken = 0;
        resolveTarget = 32'h0000_0100; resolveFallthru = 32'h0000_0204;
        #1;
        checks++; if (redirectValid !== 1'b1) $display("[TB] FAIL miss_redirect: got %b expected 1", redirectValid); else passes++;
        checks++; if (redirectPc !== 32'h0000_0100) $display("[TB] FAIL miss_pc: got %h expected %h", redirectPc, 32'h0000_0100); else passes++;
        checks++; if (stageCtrl !== 10'h00A) $display("[TB] FAIL miss_ctrl: got %h expected %h", stageCtrl, 10'h00A); else passes++;
        tick();
        clear_inputs();
        #1;
        checks++; if (stageCtrl !== 10'h000) $display("[TB] FAIL shadow_cleared: got %h expected %h", stageCtrl, 10'h000); else passes++;
        resolveValid = 1; resolveTaken = 0; resolvePredTaken = 1; resolveFallthru = 32'h0000_0204;
        #1;
        checks++; if (redirectPc !== 32'h0000_0204) $display("[TB] FAIL miss_fallthru: got %h expected %h", redirectPc, 32'h0000_0204); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        idle(3);
        src1Addr = 5'd9; src1Used = 1; fwdValid = 2'b10; fa[1] = 5'd9; fwdReady = 2'b01;
        resolveValid = 1; resolveTaken = 0; resolvePredTaken = 1;
        #1;
        checks++; if (stageCtrl !== 10'h00A) $display("[TB] FAIL miss_over_hazard: got %h expected %h", stageCtrl, 10'h00A); else passes++;
        tick();
        idle(3);
        fetchIsBranch = 1; fetchPredTaken = 0;
        tick();
        clear_inputs();
        rst = 1;
        #1;
        checks++; if (stageCtrl !== 10'h2AA) $display("[TB] FAIL mid_reset_ctrl: got %h expected %h", stageCtrl, 10'h2AA); else passes++;
        tick();
        rst = 0;
        #1;
        checks++; if (stageCtrl !== 10'h000) $display("[TB] FAIL reset_drops_shadow: got %h expected %h", stageCtrl, 10'h000); else passes++;
`ifdef HAZARD_PERF_EN
        checks++; if (perfBranchBubbles !== 32'd0) $display("[TB] FAIL perf_reset: got %0d expected 0", perfBranchBubbles); else passes++;
`endif
        tick();
    endtask

    task automatic test_hazard_hold();
        logic [9:0] want [3];
        want[0] = 10'h002; want[1] = 10'h002; want[2] = 10'h000;
        idle(3);
        fetchIsBranch = 1; fetchPredTaken = 0;
        tick();
        clear_inputs();
        src1Addr = 5'd4; src1Used = 1; fwdValid = 2'b01; fa[0] = 5'd4; fwdReady = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (stageCtrl !== 10'h009) $display("[TB] FAIL hold_hazard_%0d: got %h expected %h", c, stageCtrl, 10'h009); else passes++;
            tick();
        end
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (stageCtrl !== want[c]) $display("[TB] FAIL hold_release_%0d: got %h expected %h", c, stageCtrl, want[c]); else passes++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        bit s1, s2;
        for (int n = 0; n < 400; n++) begin
            applyStimulus_random();
            #1;
            model_bypass(src1Addr, rfSrc1Data, src1Used, e1, s1);
            model_bypass(src2Addr, rfSrc2Data, src2Used, e2, s2);
            checks++; if (bypassedSrc1 !== e1) $display("[TB] FAIL rnd_src1 @%0d: got %h expected %h", n, bypassedSrc1, e1); else passes++;
            checks++; if (bypassedSrc2 !== e2) $display("[TB] FAIL rnd_src2 @%0d: got %h expected %h", n, bypassedSrc2, e2); else passes++;
            checks++; if (dataHazard !== (s1 || s2)) $display("[TB] FAIL rnd_hazard @%0d: got %b expected %b", n, dataHazard, s1 || s2); else passes++;
            checks++; if (stageCtrl !== model_ctrl(1)) $display("[TB] FAIL rnd_ctrl @%0d: got %h expected %h", n, stageCtrl, model_ctrl(1)); else passes++;
            checks++; if (stageCtrl2 !== model_ctrl(0)) $display("[TB] FAIL rnd_ctrl_spec @%0d: got %h expected %h", n, stageCtrl2, model_ctrl(0)); else passes++;
            checks++; if (redirectValid !== (model_miss() && !rst)) $display("[TB] FAIL rnd_redirect @%0d: got %b expected %b", n, redirectValid, model_miss() && !rst); else passes++;
            checks++; if (redirectPc !== (resolveTaken ? resolveTarget : resolveFallthru)) $display("[TB] FAIL rnd_pc @%0d: got %h expected %h", n, redirectPc, resolveTaken ? resolveTarget : resolveFallthru); else passes++;
            checks++; if ({bypassedSrc1b, bypassedSrc2b, dataHazard2, redirectValid2, redirectPc2} !== {e1, e2, s1 || s2, model_miss() && !rst, redirectPc})
                $display("[TB] FAIL rnd_spec_outputs @%0d: got %h expected %h", n, {bypassedSrc1b, bypassedSrc2b, dataHazard2, redirectValid2, redirectPc2}, {e1, e2, s1 || s2, model_miss() && !rst, redirectPc}); else passes++;
`ifdef HAZARD_PERF_EN
            checks++; if ({perfStallCycles, perfFlushEvents, perfBranchBubbles} !== {32'(m_stall), 32'(m_flush), 32'(m_bubble)})
                $display("[TB] FAIL rnd_perf @%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, perfStallCycles, perfFlushEvents, perfBranchBubbles, m_stall, m_flush, m_bubble); else passes++;
`endif
            tick();
        end
        rst = 0;
    endtask

    initial begin
        $display("[TB] starting pipeline_hazard_unit bench");
        rst = 1;
        clear_inputs();
        tick();
        test_reset();
        test_bypass();
        test_data_hazard();
        test_branch_shadow();
        test_mispredict();
        test_back_to_back();
        test_hazard_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
